// File: rtl/hslp_pkg.sv
// Shared types and step constants for the sequenced 2Hx2H multiplier controller.
package hslp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] STEP_LL = 2'd0;
    localparam logic [1:0] STEP_LH = 2'd1;
    localparam logic [1:0] STEP_HL = 2'd2;
    localparam logic [1:0] STEP_HH = 2'd3;

    // Left shift applied to the partial product issued at each step.
    function automatic int unsigned step_shift(input logic [1:0] step, input int unsigned half_w);
        case (step)
            STEP_LL:          return 0;
            STEP_LH, STEP_HL: return half_w;
            default:          return 2 * half_w;
        endcase
    endfunction

endpackage

// File: rtl/hslp_seq_ctrl_if.sv
// Operand, shared-multiplier and result signals of the sequencing controller.
interface hslp_seq_ctrl_if #(
    parameter int HALF_W = 4
) ();
    logic                  in_valid;
    logic                  in_ready;
    logic [2*HALF_W-1:0]   in_a;
    logic [2*HALF_W-1:0]   in_b;
    logic [3:0]            in_mode;
    logic [HALF_W-1:0]     m_a;
    logic [HALF_W-1:0]     m_b;
    logic                  m_approx;
    logic                  m_en;
    logic [2*HALF_W-1:0]   m_prod;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*HALF_W-1:0]   out_prod;
    logic                  busy;

    modport master (
        input  in_valid, in_a, in_b, in_mode, m_prod, out_ready,
        output in_ready, m_a, m_b, m_approx, m_en, out_valid, out_prod, busy
    );

    modport slave (
        output in_valid, in_a, in_b, in_mode, m_prod, out_ready,
        input  in_ready, m_a, m_b, m_approx, m_en, out_valid, out_prod, busy
    );
endinterface

// File: rtl/hslp_shift_acc.sv
// Product accumulator: adds the step-shifted partial product each enabled cycle, modulo 2^PROD_W.
module hslp_shift_acc
    import hslp_pkg::*;
#(
    parameter int HALF_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  en,
    input  logic [1:0]            step,
    input  logic [2*HALF_W-1:0]   din,
    output logic [4*HALF_W-1:0]   acc
);
    localparam int PROD_W = 4 * HALF_W;

    logic [PROD_W-1:0] addend;

    assign addend = PROD_W'(din) << step_shift(step, HALF_W);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + addend;
        end
    end
endmodule

// File: rtl/hslp_seq_ctrl.sv
// Time-multiplexes one HxH multiplier over four cycles (LL, LH, HL, HH) to build a 2Hx2H product.
module hslp_seq_ctrl
    import hslp_pkg::*;
#(
    parameter int HALF_W = 4
) (
    input  logic          clk,
    input  logic          rst,
    hslp_seq_ctrl_if.master bus
);
    localparam int OP_W   = 2 * HALF_W;
    localparam int PROD_W = 4 * HALF_W;

    state_t              state, state_nx;
    logic [1:0]          cnt;
    logic [OP_W-1:0]     a_q, b_q;
    logic [3:0]          mode_q;
    logic [PROD_W-1:0]   acc;
    logic                accept;
    logic                in_ready, m_en, out_valid, busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        accept    = 1'b0;
        in_ready  = 1'b0;
        m_en      = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    accept   = 1'b1;
                    state_nx = MUL;
                end
            end
            MUL: begin
                m_en = 1'b1;
                busy = 1'b1;
                if (cnt == STEP_HH) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (bus.out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            mode_q <= '0;
        end else if (accept) begin
            cnt    <= '0;
            a_q    <= bus.in_a;
            b_q    <= bus.in_b;
            mode_q <= bus.in_mode;
        end else if (m_en) begin
            cnt <= cnt + 2'd1;
        end
    end

    hslp_shift_acc #(
        .HALF_W(HALF_W)
    ) u_acc (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept),
        .en   (m_en),
        .step (cnt),
        .din  (bus.m_prod),
        .acc  (acc)
    );

    // cnt bit1 selects the A half, bit0 the B half; operands are zeroed outside MUL.
    assign bus.m_a      = m_en ? (cnt[1] ? a_q[OP_W-1:HALF_W] : a_q[HALF_W-1:0]) : '0;
    assign bus.m_b      = m_en ? (cnt[0] ? b_q[OP_W-1:HALF_W] : b_q[HALF_W-1:0]) : '0;
    assign bus.m_approx = m_en & mode_q[cnt];
    assign bus.m_en     = m_en;
    assign bus.in_ready = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_prod = out_valid ? acc : '0;
    assign bus.busy     = busy;
endmodule

// File: tb/tb_hslp_seq_ctrl.sv
// Directed bench for hslp_seq_ctrl with a stub shared multiplier (approx zeroes two LSBs).
module tb_hslp_seq_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    hslp_seq_ctrl_if #(.HALF_W(4)) bus ();

    hslp_seq_ctrl #(.HALF_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] stub_prod;
    always_comb begin
        stub_prod = {4'b0, bus.m_a} * {4'b0, bus.m_b};
        if (bus.m_approx) stub_prod[1:0] = 2'b00;
        bus.m_prod = stub_prod;
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.in_valid = 0; bus.in_a = '0; bus.in_b = '0; bus.in_mode = '0; bus.out_ready = 0;
        rst = 1;
        tick(); tick();
        n_tests++;
        if ({bus.in_ready, bus.out_valid, bus.out_prod, bus.m_en, bus.m_a, bus.m_b, bus.m_approx, bus.busy}
            !== {1'b1, 1'b0, 16'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b ov=%b prod=%h en=%b a=%h b=%h ap=%b busy=%b, need rdy=1 others 0",
                     bus.in_ready, bus.out_valid, bus.out_prod, bus.m_en, bus.m_a, bus.m_b, bus.m_approx, bus.busy);
        end
        rst = 0;
        tick();
    endtask

    task automatic test_basic();
        logic [3:0] ea [4] = '{4'h7, 4'h7, 4'hB, 4'hB};
        logic [3:0] eb [4] = '{4'hC, 4'h5, 4'hC, 4'h5};
        bus.in_a = 8'hB7; bus.in_b = 8'h5C; bus.in_mode = 4'b0000; bus.in_valid = 1;
        n_tests++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL basic_idle_ready: got %b need 1", bus.in_ready);
        end
        tick();
        bus.in_valid = 0;
        for (int unsigned s = 0; s < 4; s++) begin
            n_tests++;
            if ({bus.m_en, bus.m_approx, bus.m_a, bus.m_b, bus.in_ready, bus.out_valid, bus.busy}
                !== {1'b1, 1'b0, ea[s], eb[s], 1'b0, 1'b0, 1'b1}) begin
                n_fail++;
                $display("FAIL basic_step%0d: got en=%b ap=%b a=%h b=%h rdy=%b ov=%b busy=%b need en=1 ap=0 a=%h b=%h rdy=0 ov=0 busy=1",
                         s, bus.m_en, bus.m_approx, bus.m_a, bus.m_b, bus.in_ready, bus.out_valid, bus.busy, ea[s], eb[s]);
            end
            tick();
        end
        n_tests++;
        if ({bus.out_valid, bus.out_prod, bus.in_ready, bus.m_en, bus.m_a, bus.m_b} !== {1'b1, 16'h41C4, 1'b0, 1'b0, 4'h0, 4'h0}) begin
            n_fail++;
            $display("FAIL basic_done: got ov=%b prod=%h rdy=%b en=%b a=%h b=%h need ov=1 prod=41c4 rdy=0 en=0 a=0 b=0",
                     bus.out_valid, bus.out_prod, bus.in_ready, bus.m_en, bus.m_a, bus.m_b);
        end
        bus.out_ready = 1;
        tick();
        bus.out_ready = 0;
        n_tests++;
        if ({bus.out_valid, bus.out_prod, bus.in_ready, bus.busy} !== {1'b0, 16'h0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL basic_handshake: got ov=%b prod=%h rdy=%b busy=%b need ov=0 prod=0 rdy=1 busy=0",
                     bus.out_valid, bus.out_prod, bus.in_ready, bus.busy);
        end
    endtask

    task automatic test_stall();
        bus.in_a = 8'hFF; bus.in_b = 8'hFF; bus.in_mode = 4'b0000; bus.in_valid = 1;
        tick();
        bus.in_valid = 0;
        repeat (4) tick();
        for (int unsigned i = 0; i < 10; i++) begin
            n_tests++;
            if ({bus.out_valid, bus.out_prod} !== {1'b1, 16'hFE01}) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got ov=%b prod=%h need ov=1 prod=fe01", i, bus.out_valid, bus.out_prod);
            end
            tick();
        end
        bus.out_ready = 1;
        tick();
        bus.out_ready = 0;
        n_tests++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL stall_release: got rdy=%b ov=%b need rdy=1 ov=0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_approx();
        logic eap [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        bus.in_a = 8'h37; bus.in_b = 8'h33; bus.in_mode = 4'b1010; bus.in_valid = 1;
        tick();
        bus.in_valid = 0;
        for (int unsigned s = 0; s < 4; s++) begin
            n_tests++;
            if (bus.m_approx !== eap[s]) begin
                n_fail++;
                $display("FAIL approx_step%0d: got m_approx=%b need %b", s, bus.m_approx, eap[s]);
            end
            tick();
        end
        // 21 + 20<<4 + 9<<4 + 8<<8 = 2533
        n_tests++;
        if ({bus.out_valid, bus.out_prod} !== {1'b1, 16'h09E5}) begin
            n_fail++;
            $display("FAIL approx_prod: got ov=%b prod=%h need ov=1 prod=09e5", bus.out_valid, bus.out_prod);
        end
        bus.out_ready = 1;
        tick();
        bus.out_ready = 0;
    endtask

    task automatic test_async_reset();
        bus.in_a = 8'hB7; bus.in_b = 8'h5C; bus.in_mode = 4'b1111; bus.in_valid = 1;
        tick();
        bus.in_valid = 0;
        tick(); tick();
        #2 rst = 1;
        #1;
        n_tests++;
        if ({bus.in_ready, bus.out_valid, bus.out_prod, bus.m_en, bus.m_a, bus.m_b, bus.m_approx, bus.busy}
            !== {1'b1, 1'b0, 16'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset: got rdy=%b ov=%b prod=%h en=%b a=%h b=%h ap=%b busy=%b need rdy=1 others 0",
                     bus.in_ready, bus.out_valid, bus.out_prod, bus.m_en, bus.m_a, bus.m_b, bus.m_approx, bus.busy);
        end
        @(negedge clk);
        tick();
        rst = 0;
        tick();
        bus.in_a = 8'h02; bus.in_b = 8'h03; bus.in_mode = 4'b0000; bus.in_valid = 1;
        tick();
        bus.in_valid = 0;
        repeat (4) tick();
        n_tests++;
        if ({bus.out_valid, bus.out_prod} !== {1'b1, 16'h0006}) begin
            n_fail++;
            $display("FAIL after_reset_prod: got ov=%b prod=%h need ov=1 prod=0006", bus.out_valid, bus.out_prod);
        end
        bus.out_ready = 1;
        tick();
        bus.out_ready = 0;
    endtask

    task automatic test_back_to_back();
        bus.in_a = 8'h12; bus.in_b = 8'h34; bus.in_mode = 4'b0000; bus.in_valid = 1;
        tick();
        bus.in_a = 8'h21; bus.in_b = 8'h43;
        for (int unsigned s = 0; s < 4; s++) begin
            if (s == 1) bus.in_mode = 4'b1111;
            n_tests++;
            if ({bus.m_en, bus.m_approx} !== 2'b10) begin
                n_fail++;
                $display("FAIL b2b_mode_step%0d: got en=%b ap=%b need en=1 ap=0", s, bus.m_en, bus.m_approx);
            end
            tick();
        end
        n_tests++;
        if ({bus.out_valid, bus.out_prod} !== {1'b1, 16'h03A8}) begin
            n_fail++;
            $display("FAIL b2b_first_prod: got ov=%b prod=%h need ov=1 prod=03a8", bus.out_valid, bus.out_prod);
        end
        bus.out_ready = 1;
        tick();
        bus.out_ready = 0;
        n_tests++;
        if ({bus.in_ready, bus.busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL b2b_idle_gap: got rdy=%b busy=%b need rdy=1 busy=0", bus.in_ready, bus.busy);
        end
        tick();
        bus.in_valid = 0;
        n_tests++;
        if ({bus.in_ready, bus.m_en, bus.busy, bus.m_approx} !== 4'b0111) begin
            n_fail++;
            $display("FAIL b2b_second_accept: got rdy=%b en=%b busy=%b ap=%b need rdy=0 en=1 busy=1 ap=1",
                     bus.in_ready, bus.m_en, bus.busy, bus.m_approx);
        end
        repeat (4) tick();
        // 0x21*0x43 with every partial product's two LSBs dropped: 0 + 4<<4 + 4<<4 + 8<<8
        n_tests++;
        if ({bus.out_valid, bus.out_prod} !== {1'b1, 16'h0880}) begin
            n_fail++;
            $display("FAIL b2b_second_prod: got ov=%b prod=%h need ov=1 prod=0880", bus.out_valid, bus.out_prod);
        end
        bus.out_ready = 1;
        tick();
        bus.out_ready = 0;
        bus.in_mode = 4'b0000;
    endtask

    task automatic test_spurious_ready();
        bus.out_ready = 1;
        tick(); tick();
        n_tests++;
        if ({bus.in_ready, bus.out_valid, bus.out_prod, bus.busy} !== {1'b1, 1'b0, 16'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL idle_out_ready: got rdy=%b ov=%b prod=%h busy=%b need rdy=1 ov=0 prod=0 busy=0",
                     bus.in_ready, bus.out_valid, bus.out_prod, bus.busy);
        end
        bus.out_ready = 0;
        bus.in_a = 8'h11; bus.in_b = 8'h11; bus.in_valid = 1;
        tick();
        bus.in_valid = 0;
        bus.out_ready = 1;
        tick();
        bus.out_ready = 0;
        n_tests++;
        if ({bus.m_en, bus.busy, bus.out_valid, bus.out_prod, bus.m_a, bus.m_b} !== {1'b1, 1'b1, 1'b0, 16'h0, 4'h1, 4'h1}) begin
            n_fail++;
            $display("FAIL mul_out_ready: got en=%b busy=%b ov=%b prod=%h a=%h b=%h need en=1 busy=1 ov=0 prod=0 a=1 b=1",
                     bus.m_en, bus.busy, bus.out_valid, bus.out_prod, bus.m_a, bus.m_b);
        end
        repeat (3) tick();
        n_tests++;
        if ({bus.out_valid, bus.out_prod} !== {1'b1, 16'h0121}) begin
            n_fail++;
            $display("FAIL spurious_prod: got ov=%b prod=%h need ov=1 prod=0121", bus.out_valid, bus.out_prod);
        end
        bus.out_ready = 1;
        tick();
        bus.out_ready = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_approx();
        test_async_reset();
        test_back_to_back();
        test_spurious_ready();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
